// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide unit: single-cycle MUL, 32-step restoring DIV,
// and a FIX cycle that applies signs or the divide-by-zero result.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        sgn_q, sgn_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] quot_q, quot_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dz_q, dz_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_div_s;
  logic [31:0] a_mag, b_mag;
  logic [63:0] ax, bx, prod;
  logic [32:0] trial, diff;
  logic [31:0] qfix, rfix;

  assign is_div_s = (op == 2'b10);
  assign a_mag    = (is_div_s && a[31]) ? 32'(-a) : a;
  assign b_mag    = (is_div_s && b[31]) ? 32'(-b) : b;

  // Sign-extending both factors to 64 bits makes the low 64 product bits correct for MULT too.
  assign ax   = {{32{sgn_q & a_q[31]}}, a_q};
  assign bx   = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod = ax * bx;

  // Remainder stays below the divisor, so diff[32] alone tells whether the subtract underflowed.
  assign trial = {rem_q, quot_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  assign qfix = qneg_q ? 32'(-quot_q) : quot_q;
  assign rfix = rneg_q ? 32'(-rem_q)  : rem_q;

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          sgn_d  = ~op[0];
          a_d    = a;
          b_d    = b;
          quot_d = a_mag;
          dvs_d  = b_mag;
          rem_d  = 32'd0;
          cnt_d  = 5'd0;
          dz_d   = op[1] && (b == 32'd0);
          qneg_d = is_div_s && (a[31] ^ b[31]);
          rneg_d = is_div_s && a[31];
          if (!op[1])             state_d = S_MUL;
          else if (b == 32'd0)    state_d = S_FIX;
          else                    state_d = S_DIV;
        end
      end
      S_MUL: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      S_DIV: begin
        rem_d  = diff[32] ? trial[31:0] : diff[31:0];
        quot_d = {quot_q[30:0], ~diff[32]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      default: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rfix;
          lo_d = qfix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic HI/LO model.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference from plain arithmetic: truncating signed division matches MIPS DIV.
  task automatic model(input logic [1:0] o, input logic [31:0] x, y,
                       output logic [31:0] h, output logic [31:0] l, output int lat);
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] ux, uy, up;
    sx = $signed(x); sy = $signed(y);
    ux = {32'd0, x};  uy = {32'd0, y};
    case (o)
      2'b00: begin sp = sx * sy; {h, l} = sp; lat = 2; end
      2'b01: begin up = ux * uy; {h, l} = up; lat = 2; end
      default: begin
        if (y == 32'd0) begin
          h = x; l = 32'hFFFF_FFFF; lat = 2;
        end else if (o == 2'b10) begin
          sq = sx / sy; sr = sx % sy;
          l = sq[31:0]; h = sr[31:0]; lat = 34;
        end else begin
          l = x / y; h = x % y; lat = 34;
        end
      end
    endcase
  endtask

  task automatic idle_inputs();
    start = 0; flush = 0; hi_we = 0; lo_we = 0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                        input bit noise, input bit mt, input logic [31:0] mtv);
    logic [31:0] h, l;
    int lat, n, nbusy;
    model(o, x, y, h, l, lat);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    if (mt) begin hi_we = 1; wdata = mtv; end
    @(negedge clk);
    idle_inputs();
    n = 1; nbusy = 0;
    chk("busy_t1", {63'd0, busy}, 64'd1);
    if (mt) chk("mthi_with_start", {32'd0, hi}, {32'd0, mtv});
    while (!done && n < 60) begin
      if (busy) nbusy++;
      if (noise && n == 4) begin
        start = 1; op = 2'($urandom); a = $urandom; b = $urandom;
        hi_we = 1; lo_we = 1; wdata = $urandom;
      end else idle_inputs();
      @(negedge clk);
      n++;
    end
    idle_inputs();
    chk("latency", n, lat);
    chk("busy_cycles", nbusy, lat - 1);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("result", {hi, lo}, {h, l});
    exp_hi = h; exp_lo = l;
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  task automatic abort_test(input bit use_reset);
    int saw_done;
    @(negedge clk);
    hi_we = 1; wdata = 32'h0000_AAAA;
    @(negedge clk);
    idle_inputs();
    exp_hi = 32'h0000_AAAA;
    chk("preload_hi", {32'd0, hi}, {32'd0, exp_hi});
    start = 1; op = 2'b11; a = $urandom; b = 32'd7;
    @(negedge clk);
    idle_inputs();
    saw_done = 0;
    for (int n = 1; n < 10; n++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    if (use_reset) reset = 1; else flush = 1;
    @(negedge clk);
    reset = 0; flush = 0;
    chk(use_reset ? "busy_after_reset" : "busy_after_flush", {63'd0, busy}, 64'd0);
    if (use_reset) begin exp_hi = 0; exp_lo = 0; end
    for (int n = 0; n < 40; n++) begin
      if (done) saw_done++;
      @(negedge clk);
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1; idle_inputs(); op = 0; a = 0; b = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    // reset dominates a write strobe
    hi_we = 1; wdata = 32'h1111_1111;
    @(negedge clk);
    chk("rst_over_we", {32'd0, hi}, 64'd0);
    reset = 0; idle_inputs();

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    chk("mult_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
    chk("multu_vec", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0, 0);
    chk("div_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    chk("divu_vec", {hi, lo}, 64'h8000_0000_0000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    chk("div_ovf_vec", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b10, 32'h0000_1234, 32'd0, 0, 0, 0);
    chk("div0_vec", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0010, 0, 1, 32'h5555_5555);

    // flush together with start in IDLE is not an acceptance
    @(negedge clk);
    start = 1; flush = 1; op = 2'b11; a = 32'd100; b = 32'd3;
    @(negedge clk);
    idle_inputs();
    chk("flush_blocks_start", {63'd0, busy}, 64'd0);
    // MTLO in IDLE with a flush present still writes
    lo_we = 1; flush = 1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    idle_inputs();
    exp_lo = 32'h0BAD_F00D;
    chk("mtlo_idle", {32'd0, lo}, {32'd0, exp_lo});

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, bit'($urandom), 0, 0);
    end

    abort_test(0);
    abort_test(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a mul/div operation.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  rs operand (multiplicand / dividend).
- b  in  32  rt operand (multiplier / divisor).
- flush  in  1  abort the operation in flight.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in flight; pipeline stall.
- done  out  1  one-cycle completion pulse.
- hi  out  32  HI register.
- lo  out  32  LO register.

Function
REQ-003 The FSM SHALL have the states IDLE, MUL, DIV and FIX; busy SHALL equal (state != IDLE).
REQ-004 start SHALL be accepted only in IDLE, and op, a and b SHALL be captured on that edge; start while busy SHALL be ignored.
REQ-005 MULT/MULTU, accepted at cycle T, SHALL enter MUL at T+1 with busy=1.
REQ-006 At the end of MUL cycle T+1, the block SHALL write {hi,lo} with the 64-bit signed (MULT) or unsigned (MULTU) product and return to IDLE; at T+2, done=1, busy=0, and the new HI/LO SHALL be visible.
REQ-007 DIV/DIVU with b!=0 SHALL perform radix-2 restoring division on magnitudes: |a|,|b| for DIV, raw values for DIVU; 5-bit iteration counter.
- Cycles T+1..T+32: DIV state, one quotient bit per cycle, counter 0..31.
- T+33: FIX state.
- T+34: done=1, busy=0.
REQ-008 In FIX for DIV, quotient sign SHALL be a[31]^b[31] and remainder sign SHALL be a[31]; the results are two's-complement negated when the sign bit is set. FIX SHALL write lo=quotient, hi=remainder.
REQ-009 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 (no trap, no overflow flag).
REQ-010 Divide by zero (b==0 at accept) SHALL go directly to FIX at T+1 and write hi=a, lo=0xFFFFFFFF; done SHALL pulse at T+2.
REQ-011 done SHALL be high for exactly one cycle per completed operation and never otherwise.
REQ-012 flush while busy SHALL return the FSM to IDLE on that edge with hi/lo unchanged and no done pulse; flush in IDLE SHALL have no effect; flush together with start in IDLE SHALL suppress acceptance.
REQ-013 hi_we/lo_we SHALL write wdata to hi/lo only when busy=0; while busy they SHALL be ignored.
REQ-014 hi_we/lo_we in the same cycle as an accepted start SHALL both be applied, and the later operation result SHALL overwrite the written value.
REQ-015 Internal dividend/remainder/quotient registers SHALL be at least 64 bits of datapath (remainder 33-bit for the subtract); no result bit SHALL be lost for any 32-bit operand.

Reset
REQ-016 On reset, the block SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0 and the iteration counter to 0.
REQ-017 Reset SHALL take priority over flush, start and hi_we/lo_we.
REQ-018 Reset asserted mid-operation SHALL abort the operation with no done pulse.

Verification
REQ-019 MULT a=0xFFFFFFFE, b=3 at T -> busy=1 at T+1; done=1 at T+2 with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-020 MULTU a=0xFFFFFFFE, b=3 -> hi=0x00000002, lo=0xFFFFFFFA at T+2.
REQ-021 DIV a=0xFFFFFFF9, b=2 at T -> busy T+1..T+33; done at T+34 with lo=0xFFFFFFFD, hi=0xFFFFFFFF. A start pulsed at T+5 SHALL be ignored.
REQ-022 DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-023 DIV a=0x1234, b=0 -> done at T+2 with hi=0x1234, lo=0xFFFFFFFF.
REQ-024 Preload hi=0xAAAA via hi_we; start DIVU; flush at T+10 -> busy=0 at T+11, no done, hi=0xAAAA. Repeat with reset instead of flush -> hi=lo=0, no done.
